irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt controller for the 16-bit CPU. Latches single-cycle event pulses
//  (timer pulse vectors, peripheral events) into a pending register and filters
//  them through a software-written mask. Picks the highest-priority line and
//  issues one request with a PC vector to the control unit.
//  Runs a req/ack/return handshake, so only one interrupt is in service at a time (non-nested).
// PARAMETERS
//  N_IRQ      8       number of interrupt lines (1..16)
//  PC_WIDTH   10      width of program counter / vector output
//  VEC_BASE   960     vector address of line 0 (10'h3C0)
//  VEC_STRIDE 4       address distance between consecutive line vectors
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  reset      in   1         asynchronous, active-high; clears all state
//  irq_in     in   N_IRQ     event pulses, one bit per line, sampled every cycle
//  mask_we    in   1         load mask register with mask_d
//  mask_d     in   N_IRQ     new mask value (1 = line enabled)
//  int_ack    in   1         CPU accepted request (PC saved, jumping to int_vec)
//  reti       in   1         CPU executed return-from-interrupt
//  int_req    out  1         interrupt request to control unit
//  int_vec    out  PC_WIDTH  vector address of the request being serviced
//  int_id     out  4         index of the request being serviced
//  in_service out  1         handler currently running
//  pending    out  N_IRQ     raw latched events (visible to software)
//  mask       out  N_IRQ     current mask register
// BEHAVIOUR
//  - Reset: state=IDLE; pending, mask, int_id, int_vec = 0; int_req and in_service = 0.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - Pending: pending[i] <= (pending[i] & ~clr[i]) | irq_in[i].
//    clr is one-hot on int_id only in a cycle with an accepted int_ack.
//    If set and clear hit the same bit in the same cycle, set wins, so the new event is kept.
//    A repeated pulse on an already-pending line collapses into that one pending bit.
//  - Mask: mask <= mask_d when mask_we; reset value 0 (all lines disabled).
//    Masked lines still latch in pending but never request.
//  - Priority: highest index wins among active = pending & mask.
//  - FSM:
//    IDLE: if |active, go REQ. On that edge, latch int_id = winner and
//      int_vec = VEC_BASE + int_id*VEC_STRIDE, truncated to PC_WIDTH bits.
//    REQ: int_req=1. int_id and int_vec stay frozen, even if mask or pending change.
//      A request is never withdrawn. On int_ack, clear pending[int_id] and go SVC.
//    SVC: int_req=0, in_service=1. On reti, go IDLE; in_service=0 on the next cycle.
//  - Latency: irq_in pulse in cycle t -> pending set at edge t+1 -> int_req high from edge t+2.
//    int_ack in cycle k -> int_req low and in_service high from edge k+1.
//  - After reti, a new request can rise at the earliest one cycle later (via IDLE).
//  - Ignored inputs: int_ack outside REQ; reti outside SVC. They change no state.
//  - int_ack and reti high in the same cycle: only the one valid for the current state acts.
//  - Reset asserted mid-handshake: immediate return to IDLE. int_req drops
//    asynchronously and all pending events are lost.
// TESTING
//  1. Reset, mask_we with mask_d=8'hFF, pulse irq_in=8'h80 for 1 cycle
//     -> pending=8'h80 after 1 edge; int_req=1 after 2 edges; int_id=7; int_vec=988.
//  2. From 1: int_ack for 1 cycle -> int_req=0, in_service=1, pending=0.
//     Then reti -> in_service=0; int_req stays 0.
//  3. mask=8'h01, irq_in=8'h81 together
//     -> only line 0 requested (int_vec=960); pending stays 8'h80.
//     Write mask=8'hFF during SVC -> line 7 requested 2 cycles after reti.
//  4. Pulse line 3 in the same cycle as int_ack of line 3
//     -> pending[3] stays 1; a new request for id 3 follows the reti.
//  5. Line 2 requesting, pulse line 6 while in REQ -> int_id/int_vec stay 2/968.
//     After ack and reti, line 6 is serviced with int_vec=984.
//  6. Assert reset while in SVC -> all outputs 0 in the same cycle.
//     Spurious reti and int_ack while IDLE -> no state change.

Source files
------------

// File: rtl/irq_controller.sv
// Non-nested interrupt controller: latches event pulses into a pending register,
// masks them, and runs a req/ack/reti handshake for the highest-index active line.
module irq_controller #(
    parameter int N_IRQ      = 8,
    parameter int PC_WIDTH   = 10,
    parameter int VEC_BASE   = 960,
    parameter int VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IRQ-1:0]    irq_in,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_d,
    input  logic                int_ack,
    input  logic                reti,
    output logic                int_req,
    output logic [PC_WIDTH-1:0] int_vec,
    output logic [3:0]          int_id,
    output logic                in_service,
    output logic [N_IRQ-1:0]    pending,
    output logic [N_IRQ-1:0]    mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [N_IRQ-1:0]    r_pending;
    logic [N_IRQ-1:0]    r_mask;
    logic [3:0]          r_int_id;
    logic [PC_WIDTH-1:0] r_int_vec;
    logic                r_int_req;
    logic                r_in_service;

    logic [N_IRQ-1:0]    w_active;
    logic [N_IRQ-1:0]    w_clr;
    logic [N_IRQ-1:0]    w_pending_next;
    logic [3:0]          w_winner;
    logic [PC_WIDTH-1:0] w_winner_vec;
    logic                w_ack_ok;
    logic                w_take;

    assign w_active = r_pending & r_mask;
    assign w_ack_ok = (r_state == ST_REQ) && int_ack;
    assign w_take   = (r_state == ST_IDLE) && (|w_active);

    // Clear only the line being acknowledged; a same-cycle pulse re-sets it.
    assign w_clr          = w_ack_ok ? (N_IRQ'(1) << r_int_id) : '0;
    assign w_pending_next = (r_pending & ~w_clr) | irq_in;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_winner = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_active[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    // Modular PC_WIDTH arithmetic gives the truncated vector directly.
    assign w_winner_vec = PC_WIDTH'(VEC_BASE) + PC_WIDTH'(w_winner) * PC_WIDTH'(VEC_STRIDE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (|w_active) w_state_next = ST_REQ;
            ST_REQ:  if (int_ack)   w_state_next = ST_SVC;
            ST_SVC:  if (reti)      w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_mask       <= '0;
            r_int_id     <= '0;
            r_int_vec    <= '0;
            r_int_req    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (mask_we) begin
                r_mask <= mask_d;
            end
            // id/vector are captured once on entry to REQ and frozen until the next entry.
            if (w_take) begin
                r_int_id  <= w_winner;
                r_int_vec <= w_winner_vec;
            end
            r_int_req    <= (w_state_next == ST_REQ);
            r_in_service <= (w_state_next == ST_SVC);
        end
    end

    assign int_req    = r_int_req;
    assign int_vec    = r_int_vec;
    assign int_id     = r_int_id;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller: a behavioural model predicts each
// request; a monitor pops the expected id/vector whenever int_req rises.
module tb_irq_controller;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_d;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [9:0] int_vec;
    logic [3:0] int_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] mask;

    irq_controller #(
        .N_IRQ(8), .PC_WIDTH(10), .VEC_BASE(960), .VEC_STRIDE(4)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_d(mask_d),
        .int_ack(int_ack), .reti(reti), .int_req(int_req), .int_vec(int_vec),
        .int_id(int_id), .in_service(in_service), .pending(pending), .mask(mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] id;
        logic [9:0] vec;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: phase 0 = idle, 1 = request outstanding, 2 = handler running.
    bit [7:0] m_pend, m_mask;
    int       m_phase;
    bit [3:0] m_id;
    bit [9:0] m_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_phase = 0; m_id = 0; m_vec = 0;
    endtask

    task automatic model_step();
        bit [7:0] act;
        bit [7:0] clr;
        exp_t     e;
        act = m_pend & m_mask;
        clr = (m_phase == 1 && int_ack) ? 8'(1 << m_id) : 8'h00;
        case (m_phase)
            0: if (act != 0) begin
                m_id  = 4'($clog2(int'(act) + 1) - 1);
                m_vec = 10'((960 + 4 * int'(m_id)) % 1024);
                e.id  = m_id;
                e.vec = m_vec;
                exp_q.push_back(e);
                m_phase = 1;
            end
            1: if (int_ack) m_phase = 2;
            2: if (reti) m_phase = 0;
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~clr) | irq_in;
        if (mask_we) m_mask = mask_d;
    endtask

    task automatic compare_all();
        check("int_req", 32'(int_req), 32'(m_phase == 1));
        check("in_service", 32'(in_service), 32'(m_phase == 2));
        check("pending", 32'(pending), 32'(m_pend));
        check("mask", 32'(mask), 32'(m_mask));
        check("int_id", 32'(int_id), 32'(m_id));
        check("int_vec", 32'(int_vec), 32'(m_vec));
    endtask

    // Inputs are applied at the falling edge, outputs compared at the next falling edge.
    task automatic cyc(input logic [7:0] irq, input logic mwe, input logic [7:0] md,
                       input logic ack, input logic rt);
        irq_in = irq; mask_we = mwe; mask_d = md; int_ack = ack; reti = rt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        irq_in = 0; mask_we = 0; mask_d = 0; int_ack = 0; reti = 0;
    endtask

    task automatic idle();
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is raised between clock edges so the asynchronous clear is observable at once.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (int_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_req", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_id", 32'(int_id), 32'(e.id));
                    check("sb_vec", 32'(int_vec), 32'(e.vec));
                end
            end
            prev_req = int_req;
        end
    end

    initial begin
        reset = 1'b1; irq_in = 0; mask_we = 0; mask_d = 0; int_ack = 0; reti = 0;
        model_reset();
        #2;
        check("rst_int_req", 32'(int_req), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_mask", 32'(mask), 32'd0);
        check("rst_int_vec", 32'(int_vec), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Highest line with all lines enabled.
        cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_pending", 32'(pending), 32'h80);
        check("t1_req_early", 32'(int_req), 32'd0);
        idle();
        check("t1_req", 32'(int_req), 32'd1);
        check("t1_id", 32'(int_id), 32'd7);
        check("t1_vec", 32'(int_vec), 32'd988);

        // Acknowledge and return.
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_req", 32'(int_req), 32'd0);
        check("t2_svc", 32'(in_service), 32'd1);
        check("t2_pending", 32'(pending), 32'd0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_svc_off", 32'(in_service), 32'd0);
        idle();
        check("t2_req_stays", 32'(int_req), 32'd0);

        // Masked line latches but does not request until unmasked.
        cyc(8'h81, 1'b1, 8'h01, 1'b0, 1'b0);
        idle();
        check("t3_req", 32'(int_req), 32'd1);
        check("t3_vec", 32'(int_vec), 32'd960);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_pending", 32'(pending), 32'h80);
        cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_gap", 32'(int_req), 32'd0);
        idle();
        check("t3_req7", 32'(int_req), 32'd1);
        check("t3_id7", 32'(int_id), 32'd7);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Set wins over the acknowledge clear on the same line.
        cyc(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        check("t4_id", 32'(int_id), 32'd3);
        cyc(8'h08, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_pending", 32'(pending), 32'h08);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        check("t4_rereq", 32'(int_req), 32'd1);
        check("t4_reid", 32'(int_id), 32'd3);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Request is frozen while a higher line arrives.
        cyc(8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        cyc(8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_id", 32'(int_id), 32'd2);
        check("t5_vec", 32'(int_vec), 32'd968);
        idle();
        check("t5_frozen", 32'(int_id), 32'd2);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        check("t5_id6", 32'(int_id), 32'd6);
        check("t5_vec6", 32'(int_vec), 32'd984);

        // Reset in service, then spurious handshake inputs while idle.
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_svc", 32'(in_service), 32'd1);
        do_reset();
        check("t6_rst_svc", 32'(in_service), 32'd0);
        check("t6_rst_id", 32'(int_id), 32'd0);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        check("t6_spur_req", 32'(int_req), 32'd0);
        check("t6_spur_svc", 32'(in_service), 32'd0);

        // Random traffic, including out-of-state ack/reti and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc(8'($urandom & $urandom & $urandom),
                    ($urandom_range(0, 15) == 0),
                    8'($urandom),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0));
            end
        end

        idle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
